// File: rtl/fpu_mult_sched.sv
// fpu_mult_sched
//   Round-robin scheduler sharing one pipelined FP32 multiply datapath
//   between two requesters. Accepted operand pairs are issued one per cycle.
//   The owner of each in-flight operation is remembered in a small FIFO, so
//   results (which return in issue order) are routed back to the right
//   requester. A drain/halt mechanism lets the pipeline be emptied before
//   reconfiguration.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0_* / req1_*          valid/ready operand-pair interfaces per requester
//   issue_valid/_a/_b        registered operands presented to the datapath
//   dp_valid, dp_result      in-order datapath results (no backpressure)
//   resp0_valid/resp1_valid  registered one-cycle result pulse per requester
//   resp_data                registered result shared by both response ports
//   drain, drained           drain request level / pipeline halted and empty
//   inflight                 operations issued but not yet returned
//   err_underflow            sticky: result arrived with no recorded owner
module fpu_mult_sched #(
  parameter int DATA_W       = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              issue_valid,
  output logic [DATA_W-1:0] issue_a,
  output logic [DATA_W-1:0] issue_b,
  input  logic              dp_valid,
  input  logic [DATA_W-1:0] dp_result,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_data,
  input  logic              drain,
  output logic              drained,
  output logic [CNT_W-1:0]  inflight,
  output logic              err_underflow
);

  localparam int PTR_W = $clog2(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             grant_idx;
  logic             can_accept;
  logic             handshake;
  logic             pop;
  logic             fifo_empty;
  logic             pop_owner;
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             owner_mem [MAX_INFLIGHT];
  logic [CNT_W-1:0] inflight_next;

  // Acceptance is gated on the registered in-flight count, so a pop in the
  // same cycle never re-opens a full pipeline until the following cycle.
  assign can_accept = (state == ST_RUN) && (inflight < CNT_W'(MAX_INFLIGHT));

  // Round-robin arbitration: a lone requester always wins, a tie goes to
  // whoever was not granted last.
  always_comb begin
    grant_idx = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_idx = ~last_grant;
    end else if (req1_valid) begin
      grant_idx = 1'b1;
    end
  end

  assign req0_ready = can_accept && req0_valid && !grant_idx;
  assign req1_ready = can_accept && req1_valid &&  grant_idx;
  assign handshake  = req0_ready || req1_ready;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign pop        = dp_valid && !fifo_empty;
  assign pop_owner  = owner_mem[rd_ptr[PTR_W-1:0]];
  assign drained    = (state == ST_HALT);

  // Count after this edge; the drain logic uses it so HALT is entered on the
  // same edge that retires the last operation.
  always_comb begin
    inflight_next = inflight;
    case ({handshake, pop})
      2'b10:   inflight_next = inflight + CNT_W'(1);
      2'b01:   inflight_next = inflight - CNT_W'(1);
      default: inflight_next = inflight;
    endcase
  end

  // Control FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (drain) begin
          state_next = (inflight_next == '0) ? ST_HALT : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight_next == '0) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!drain) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // State, arbitration history, FIFO pointers and all registered outputs.
  // A reset throws away ownership of anything still in the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RUN;
      last_grant    <= 1'b1;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      inflight      <= '0;
      issue_valid   <= 1'b0;
      issue_a       <= '0;
      issue_b       <= '0;
      resp0_valid   <= 1'b0;
      resp1_valid   <= 1'b0;
      resp_data     <= '0;
      err_underflow <= 1'b0;
    end else begin
      state       <= state_next;
      inflight    <= inflight_next;
      issue_valid <= handshake;
      resp0_valid <= pop && !pop_owner;
      resp1_valid <= pop &&  pop_owner;
      if (handshake) begin
        issue_a    <= grant_idx ? req1_a : req0_a;
        issue_b    <= grant_idx ? req1_b : req0_b;
        last_grant <= grant_idx;
        wr_ptr     <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        resp_data <= dp_result;
        rd_ptr    <= rd_ptr + (PTR_W+1)'(1);
      end
      if (dp_valid && fifo_empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // Owner storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (handshake) begin
      owner_mem[wr_ptr[PTR_W-1:0]] <= grant_idx;
    end
  end

endmodule

// File: doc/fpu_mult_sched.md
Name: fpu_mult_sched

Overview:
- Round-robin scheduler that shares one pipelined FP32 multiply+normalize datapath between two requesters.
- Accepts operand pairs over valid/ready, issues them to the datapath one per cycle, and tracks which requester owns each in-flight operation in an owner FIFO.
- Routes each datapath result back to its owner in issue order.
- Supports drain/halt so the pipeline can be emptied before reconfiguration or rounding-mode changes.

Parameters:
DATA_W, 32, operand/result width (FP32)
MAX_INFLIGHT, 4, max operations issued but not yet returned; owner-FIFO depth (power of 2, ≥2)
CNT_W, 3, in-flight counter width; must hold 0..MAX_INFLIGHT

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operand pair
req0_a  in  DATA_W  requester 0 operand A
req0_b  in  DATA_W  requester 0 operand B
req0_ready  out  1  requester 0 handshake accepted this cycle
req1_valid  in  1  requester 1 has an operand pair
req1_a  in  DATA_W  requester 1 operand A
req1_b  in  DATA_W  requester 1 operand B
req1_ready  out  1  requester 1 handshake accepted this cycle
issue_valid  out  1  registered; operands presented to datapath
issue_a  out  DATA_W  registered operand A to datapath
issue_b  out  DATA_W  registered operand B to datapath
dp_valid  in  1  datapath result valid (in issue order, no backpressure)
dp_result  in  DATA_W  datapath result
resp0_valid  out  1  registered result pulse to requester 0
resp1_valid  out  1  registered result pulse to requester 1
resp_data  out  DATA_W  registered result, shared by both resp ports
drain  in  1  level; stop accepting, empty pipeline
drained  out  1  high in HALT state
inflight  out  CNT_W  current in-flight count
err_underflow  out  1  sticky: dp_valid seen with owner FIFO empty

Behaviour:
- Reset (rst=1 at clk edge): state=RUN, inflight=0, FIFO pointers=0, last_grant=1 (so requester 0 wins first tie), err_underflow=0. All registered outputs are 0, including issue_a/b and resp_data. rst mid-operation discards in-flight ownership; dp_valid results arriving later raise err_underflow.
- States:
  - RUN: accepts requests. drain=1 -> DRAIN.
  - DRAIN: no acceptance. When inflight==0 and no accept pending -> HALT (same edge if already 0).
  - HALT: drained=1, no acceptance. drain=0 -> RUN.
- can_accept = (state==RUN) && (inflight < MAX_INFLIGHT).
- Arbitration is combinational from valids, last_grant and can_accept:
  - Only one valid: that requester is granted.
  - Both valid: grant !last_grant.
  - reqN_ready = grant==N && reqN_valid && can_accept; at most one ready per cycle. Handshake = valid&&ready.
- On handshake (edge):
  - issue_valid<=1; issue_a/b<=granted operands.
  - Push granted index to owner FIFO.
  - last_grant<=granted index.
  - Without a handshake, issue_valid<=0 and issue_a/b hold.
  - Latency: request handshake to issue_valid is 1 cycle.
- On dp_valid with FIFO non-empty (edge):
  - Pop owner; resp_data<=dp_result; resp{owner}_valid<=1 for one cycle, the other port 0.
  - Latency: dp_valid to resp pulse is 1 cycle.
- dp_valid with FIFO empty: no pop, no resp pulse, err_underflow<=1 (cleared only by rst).
- inflight: +1 on handshake, -1 on valid pop; both in same cycle -> unchanged. Never exceeds MAX_INFLIGHT; a full pipeline deasserts both readys. A pop in the same cycle does not re-enable ready (can_accept uses registered inflight).
- drain asserted while a handshake occurs in the same cycle: handshake still completes (ready was computed in RUN); state->DRAIN.

Test Plan:
- Single request: req0 a=0x3FC00000 b=0x40000000 handshake at cycle 0 -> issue_valid=1 cycle 1 with same operands; dp_valid with dp_result=0x40400000 at cycle 5 -> resp0_valid=1, resp_data=0x40400000 at cycle 6, inflight back to 0.
- Fairness: both requesters valid continuously for 6 cycles, datapath returns every issue -> grants alternate 0,1,0,1,0,1; resp pulses return in the same owner order.
- Full: req0 held valid, dp_valid held 0 -> exactly 4 handshakes, inflight=4, req0_ready=0 thereafter. One dp_valid -> ready high again the following cycle.
- Drain: 3 in flight, drain=1 -> no further readys. After 3 dp_valid pops, drained=1 on the edge where inflight reaches 0. drain=0 -> next request accepted.
- Simultaneous: handshake and dp_valid in same cycle with inflight=2 -> inflight stays 2, resp pulse and issue_valid both asserted next cycle.
- Error/reset: dp_valid with inflight=0 -> err_underflow=1, no resp pulse. rst=1 for one cycle with 2 in flight -> all outputs 0, inflight=0, state RUN.
